// File: rtl/serial_word_collector.sv
// Assembles an LSB-first serial bit stream into WIDTH-bit words and hands each
// finished word to a single-entry valid/ready buffer; lost words set a sticky overrun.
module serial_word_collector #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_shift;
  logic [CW-1:0]    pos;
  logic             complete;
  logic             accept;
  logic             drop;

  // A frame boundary restarts capture at bit 0 and throws away any partial word.
  always_comb begin
    pos        = frame_start ? '0 : bit_count;
    next_shift = frame_start ? '0 : shift_reg;
    next_shift[pos] = bit_in;
    complete   = bit_valid && (pos == CW'(WIDTH - 1));
    accept     = complete && (!word_valid || word_ready);
    drop       = complete && word_valid && !word_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_count  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (bit_valid) begin
        shift_reg <= next_shift;
        bit_count <= complete ? '0 : pos + 1'b1;
      end else if (frame_start) begin
        bit_count <= '0;
      end

      // Loading on a draining edge keeps back-to-back words bubble-free.
      if (accept) begin
        word_out   <= next_shift;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready && !complete) begin
        word_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
